// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Main controller for the 16-bit multi-cycle datapath. Every instruction is
// sequenced through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The controller
// handshakes with a variable-latency memory, aborts a stalled access after
// TIMEOUT wait cycles, traps undecodable opcodes and counts retired
// instructions.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   opcode       IR opcode field, captured in DECODE
//   funct        IR funct field, captured in DECODE
//   memReady     memory completes the current access this cycle
//   halt         hold in FETCH without issuing a new fetch
//   pcWrite      PC <= PC + 1 (fetch complete)
//   pcWriteCond  PC <= branch target when the ALU result is non-zero
//   irWrite      load IR from memory data
//   memRead      memory read request
//   memWrite     memory write request
//   regDest, aluSrc, memToReg, regWrite, branch, extOp  datapath controls
//   aluCtr       ALU operation select
//   state        current state (FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4)
//   illegalOp    one-cycle pulse: undecodable opcode seen in DECODE
//   memErr       one-cycle pulse: memory access timed out
//   instrCount   retired-instruction counter, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int OPCODE_W = 4,
  parameter int FUNCT_W  = 4,
  parameter int ALUCTR_W = 3,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                memReady,
  input  logic                halt,
  output logic                pcWrite,
  output logic                pcWriteCond,
  output logic                irWrite,
  output logic                memRead,
  output logic                memWrite,
  output logic                regDest,
  output logic                aluSrc,
  output logic                memToReg,
  output logic                regWrite,
  output logic                branch,
  output logic                extOp,
  output logic [ALUCTR_W-1:0] aluCtr,
  output logic [2:0]          state,
  output logic                illegalOp,
  output logic                memErr,
  output logic [CNT_W-1:0]    instrCount
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  // Full-width constants: any set bit above opcode[3:0] makes an opcode illegal.
  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_BNQ  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(5);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [2:0]          state_q,  state_d;
  logic [OPCODE_W-1:0] op_q,     op_d;
  logic [FUNCT_W-1:0]  funct_q,  funct_d;
  logic [WAIT_W-1:0]   wait_q,   wait_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic                wait_limit;

  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return op inside {OP_R, OP_ANDI, OP_ORI, OP_BNQ, OP_LW, OP_SW};
  endfunction

  assign wait_limit = (wait_q == WAIT_W'(TIMEOUT));

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    funct_d     = funct_q;
    wait_d      = wait_q;
    cnt_d       = cnt_q;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    irWrite     = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    regDest     = 1'b0;
    aluSrc      = 1'b0;
    memToReg    = 1'b0;
    regWrite    = 1'b0;
    branch      = 1'b0;
    extOp       = 1'b0;
    aluCtr      = '0;
    illegalOp   = 1'b0;
    memErr      = 1'b0;
    state       = state_q;

    // ALU setup is held through MEM so the address stays stable during the access.
    if (state_q == S_EXEC || state_q == S_MEM) begin
      aluSrc = op_q inside {OP_ANDI, OP_ORI, OP_LW, OP_SW};
      extOp  = op_q inside {OP_ANDI, OP_BNQ, OP_LW, OP_SW};
      case (op_q)
        OP_R:        aluCtr = funct_q[ALUCTR_W-1:0];
        OP_ANDI:     aluCtr = ALUCTR_W'(0);
        OP_ORI:      aluCtr = ALUCTR_W'(1);
        OP_BNQ:      aluCtr = ALUCTR_W'(3);
        OP_LW, OP_SW: aluCtr = ALUCTR_W'(2);
        default:     aluCtr = '0;
      endcase
    end

    case (state_q)
      S_FETCH: begin
        // A halted fetch issues no request and does not age the timeout.
        if (!halt) begin
          memRead = 1'b1;
          if (memReady) begin
            pcWrite = 1'b1;
            irWrite = 1'b1;
            state_d = S_DECODE;
          end else if (wait_limit) begin
            memErr = 1'b1;
            wait_d = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      S_DECODE: begin
        op_d    = opcode;
        funct_d = funct;
        if (is_legal(opcode)) begin
          state_d = S_EXEC;
        end else begin
          illegalOp = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_BNQ: begin
            branch      = 1'b1;
            pcWriteCond = 1'b1;
            state_d     = S_FETCH;
            cnt_d       = cnt_q + CNT_W'(1);
          end
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        memRead  = (op_q == OP_LW);
        memWrite = (op_q == OP_SW);
        // Completion on the limit cycle wins over the timeout.
        if (memReady) begin
          if (op_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else if (wait_limit) begin
          memErr  = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        regWrite = 1'b1;
        regDest  = (op_q == OP_R);
        memToReg = (op_q == OP_LW);
        state_d  = S_FETCH;
        cnt_d    = cnt_q + CNT_W'(1);
      end
      default: state_d = S_FETCH;
    endcase

    // The wait counter restarts whenever a memory-facing state is entered.
    if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM)) begin
      wait_d = '0;
    end

    // Controls are forced quiet for the whole time reset is held, not just
    // after the first reset edge.
    if (rst) begin
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      irWrite     = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      regDest     = 1'b0;
      aluSrc      = 1'b0;
      memToReg    = 1'b0;
      regWrite    = 1'b0;
      branch      = 1'b0;
      extOp       = 1'b0;
      aluCtr      = '0;
      illegalOp   = 1'b0;
      memErr      = 1'b0;
      state       = S_FETCH;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instrCount = cnt_q;

  // Funct bits above the ALU control width are captured but never decoded.
  if (FUNCT_W > ALUCTR_W) begin : g_funct_hi
    logic unused_funct_hi;
    assign unused_funct_hi = ^funct_q[FUNCT_W-1:ALUCTR_W];
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Drives directed and randomized instructions into multicycle_control_unit.
// Each instruction is expanded into its expected per-cycle phase list from the
// instruction class and the memory latency, and every cycle the full control
// vector is compared with the vector implied by that phase.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  opcode;
  logic [3:0]  funct;
  logic        memReady;
  logic        halt;
  logic        pcWrite, pcWriteCond, irWrite, memRead, memWrite;
  logic        regDest, aluSrc, memToReg, regWrite, branch, extOp;
  logic [2:0]  aluCtr;
  logic [2:0]  state;
  logic        illegalOp, memErr;
  logic [15:0] instrCount;

  int n_cmp     = 0;
  int n_err     = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .memReady   (memReady),
    .halt       (halt),
    .pcWrite    (pcWrite),
    .pcWriteCond(pcWriteCond),
    .irWrite    (irWrite),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .regDest    (regDest),
    .aluSrc     (aluSrc),
    .memToReg   (memToReg),
    .regWrite   (regWrite),
    .branch     (branch),
    .extOp      (extOp),
    .aluCtr     (aluCtr),
    .state      (state),
    .illegalOp  (illegalOp),
    .memErr     (memErr),
    .instrCount (instrCount)
  );

  // {pcWrite,pcWriteCond,irWrite,memRead,memWrite,regDest,aluSrc,memToReg,
  //  regWrite,branch,extOp,illegalOp,memErr,aluCtr[2:0],state[2:0]}
  logic [18:0] dut_vec;
  assign dut_vec = {pcWrite, pcWriteCond, irWrite, memRead, memWrite, regDest,
                    aluSrc, memToReg, regWrite, branch, extOp, illegalOp,
                    memErr, aluCtr, state};

  localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected control vector for one cycle of an instruction of opcode op.
  function automatic logic [18:0] exp_vec(input int ph, input bit rdy, input bit hlt,
                                          input bit to, input logic [3:0] op,
                                          input logic [3:0] fn);
    logic pw, pwc, iw, mr, mw, rd, src, m2r, rw, br, ext, il, me;
    logic [2:0] alu;
    logic [2:0] fn3;
    fn3 = fn[2:0];
    {pw, pwc, iw, mr, mw, rd, src, m2r, rw, br, ext, il, me} = '0;
    alu = 3'b000;
    if (ph == PH_E || ph == PH_M) begin
      src = (op == 1 || op == 2 || op == 4 || op == 5);
      ext = (op == 1 || op == 3 || op == 4 || op == 5);
      if (op == 0)      alu = fn3;
      else if (op == 2) alu = 3'b001;
      else if (op == 3) alu = 3'b011;
      else if (op >= 4) alu = 3'b010;
    end
    case (ph)
      PH_F: begin
        mr = !hlt;
        pw = rdy && !hlt;
        iw = rdy && !hlt;
        me = to;
      end
      PH_D: il = (op > 5);
      PH_E: begin
        br  = (op == 3);
        pwc = (op == 3);
      end
      PH_M: begin
        mr = (op == 4);
        mw = (op == 5);
        me = to;
      end
      PH_W: begin
        rw  = 1'b1;
        rd  = (op == 0);
        m2r = (op == 4);
      end
      default: ;
    endcase
    return {pw, pwc, iw, mr, mw, rd, src, m2r, rw, br, ext, il, me, alu, 3'(ph)};
  endfunction

  // One clock: drive inputs just after the falling edge, compare, move on.
  task automatic cycle(input int ph, input bit rdy, input bit hlt, input bit to,
                       input logic [3:0] eop, input logic [3:0] efn,
                       input logic [3:0] dop, input logic [3:0] dfn);
    memReady = rdy;
    halt     = hlt;
    opcode   = dop;
    funct    = dfn;
    #1;
    chk($sformatf("ph%0d_op%0h_fn%0h", ph, eop, efn), {13'd0, dut_vec},
        {13'd0, exp_vec(ph, rdy, hlt, to, eop, efn)});
    @(negedge clk);
  endtask

  // Run one instruction from FETCH back to FETCH. fwait = memReady-low cycles
  // before the fetch completes (<=15); mwait = low cycles in MEM (>=16 times out).
  task automatic run_instr(input logic [3:0] op, input logic [3:0] fn,
                           input int fwait, input int mwait);
    bit retired;
    int lows;
    retired = (op <= 5);
    for (int i = 0; i < fwait; i++) cycle(PH_F, 1'b0, 1'b0, 1'b0, op, fn, op, fn);
    cycle(PH_F, 1'b1, 1'b0, 1'b0, op, fn, op, fn);
    cycle(PH_D, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, op, fn, op, fn);
    if (op <= 5) begin
      // After DECODE the IR fields are scrambled; the captured copy must be used.
      cycle(PH_E, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, op, fn,
            4'($urandom), 4'($urandom));
      if (op == 4 || op == 5) begin
        lows = (mwait >= 16) ? 15 : mwait;
        for (int i = 0; i < lows; i++)
          cycle(PH_M, 1'b0, 1'b0, 1'b0, op, fn, 4'($urandom), 4'($urandom));
        if (mwait >= 16) begin
          cycle(PH_M, 1'b0, 1'b0, 1'b1, op, fn, 4'($urandom), 4'($urandom));
          retired = 1'b0;
        end else begin
          cycle(PH_M, 1'b1, 1'b0, 1'b0, op, fn, 4'($urandom), 4'($urandom));
          if (op == 4)
            cycle(PH_W, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, op, fn,
                  4'($urandom), 4'($urandom));
        end
      end else if (op != 3) begin
        cycle(PH_W, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, op, fn,
              4'($urandom), 4'($urandom));
      end
    end
    if (retired) model_cnt++;
    chk($sformatf("instr_count_op%0h", op), {16'd0, instrCount}, {16'd0, 16'(model_cnt)});
  endtask

  initial begin
    logic [3:0] rop;
    int         sel;
    int         mw;

    rst      = 1'b1;
    opcode   = 4'd0;
    funct    = 4'd0;
    memReady = 1'b1;
    halt     = 1'b0;

    // Outputs are quiet while reset is held, even with memReady high in FETCH.
    @(negedge clk);
    #1 chk("reset_hold_outputs", {13'd0, dut_vec}, 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    halt     = 1'b1;
    memReady = 1'b0;
    #1 chk("post_reset_state", {13'd0, dut_vec}, {13'd0, exp_vec(PH_F, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0)});
    chk("post_reset_count", {16'd0, instrCount}, 32'd0);
    @(negedge clk);

    // Directed instruction set coverage and latency boundaries.
    run_instr(4'b0000, 4'b0110, 0, 0);   // R-type, aluCtr=110
    run_instr(4'b0100, 4'b1011, 0, 3);   // LW, three wait cycles in MEM
    run_instr(4'b0011, 4'b0000, 0, 0);   // BNQ
    run_instr(4'b1001, 4'b0101, 0, 0);   // illegal opcode
    run_instr(4'b0101, 4'b0010, 0, 20);  // SW, memory never answers -> timeout
    run_instr(4'b0100, 4'b0001, 2, 15);  // LW, memReady on the limit cycle wins
    run_instr(4'b0001, 4'b1111, 1, 0);   // ANDI
    run_instr(4'b0010, 4'b1000, 0, 0);   // ORI
    run_instr(4'b0101, 4'b0100, 3, 1);   // SW normal
    run_instr(4'b0000, 4'b1111, 15, 0);  // fetch answered on the limit cycle

    // Fetch timeout: sixteenth unanswered cycle raises memErr, stays in FETCH.
    for (int i = 0; i < 15; i++) cycle(PH_F, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    cycle(PH_F, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    run_instr(4'b0001, 4'b0011, 4, 0);   // wait count restarted after the abort

    // Halt suppresses fetch with memory ready, and does not age the timeout.
    for (int i = 0; i < 5; i++)  cycle(PH_F, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 20; i++) cycle(PH_F, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    run_instr(4'b0010, 4'b0001, 14, 0);

    // Reset in the middle of an LW memory access.
    cycle(PH_F, 1'b1, 1'b0, 1'b0, 4'd4, 4'd0, 4'd4, 4'd0);
    cycle(PH_D, 1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 4'd4, 4'd0);
    cycle(PH_E, 1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 4'd4, 4'd0);
    cycle(PH_M, 1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 4'd4, 4'd0);
    rst      = 1'b1;
    memReady = 1'b0;
    #1 chk("rst_mid_mem_outputs", {13'd0, dut_vec}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    halt = 1'b1;
    #1 chk("rst_mid_mem_state", {13'd0, dut_vec}, {13'd0, exp_vec(PH_F, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0)});
    chk("rst_mid_mem_count", {16'd0, instrCount}, 32'd0);
    model_cnt = 0;
    @(negedge clk);
    halt = 1'b0;

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      rop = (sel <= 5) ? 4'(sel) : 4'($urandom_range(6, 15));
      mw  = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 18) : $urandom_range(0, 4);
      run_instr(rop, 4'($urandom), $urandom_range(0, 4), mw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
